// File: rtl/bit_debouncer.sv
// Bit debouncer: a 2-flop synchronizer feeds a four-state qualifier. The
// qualifier accepts a new level only after DEBOUNCE_CYCLES consecutive
// mismatching samples. Each accepted transition raises a registered one-cycle
// rise or fall pulse. Accepted rising edges are counted in a wrapping event
// counter that can be cleared.
module bit_debouncer #(
  parameter int unsigned DEBOUNCE_CYCLES = 8,
  parameter int unsigned COUNT_W         = 16
) (
  input  logic               i_clk,
  input  logic               i_reset,
  input  logic               i_d,
  input  logic               i_clear,
  output logic               o_level,
  output logic               o_rise,
  output logic               o_fall,
  output logic               o_busy,
  output logic [COUNT_W-1:0] o_event_count
);

  // Wide enough to hold DEBOUNCE_CYCLES without wrapping.
  localparam int unsigned CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  // The counter value on the edge that observes the last required mismatch.
  localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [1:0] {
    STABLE_LO = 2'd0,
    CHECK_HI  = 2'd1,
    STABLE_HI = 2'd2,
    CHECK_LO  = 2'd3
  } state_e;

  logic               sync1_q, sync2_q;
  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               level_q, level_d;
  logic               rise_q, rise_d;
  logic               fall_q, fall_d;
  logic [COUNT_W-1:0] count_q, count_d;

  // Next-state logic: qualify sync2 against the current debounced level.
  always_comb begin
    // NOTE: every variable is given a default first, so no path can infer a latch.
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = level_q;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    unique case (state_q)
      STABLE_LO: begin
        if (sync2_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            level_d = 1'b1;
            rise_d  = 1'b1;
            state_d = STABLE_HI;
          end else begin
            state_d = CHECK_HI;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      CHECK_HI: begin
        if (!sync2_q) begin
          state_d = STABLE_LO;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          level_d = 1'b1;
          rise_d  = 1'b1;
          cnt_d   = '0;
          state_d = STABLE_HI;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STABLE_HI: begin
        if (!sync2_q) begin
          if (DEBOUNCE_CYCLES == 1) begin
            level_d = 1'b0;
            fall_d  = 1'b1;
            state_d = STABLE_LO;
          end else begin
            state_d = CHECK_LO;
            cnt_d   = CNT_W'(1);
          end
        end
      end
      CHECK_LO: begin
        if (sync2_q) begin
          state_d = STABLE_HI;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          level_d = 1'b0;
          fall_d  = 1'b1;
          cnt_d   = '0;
          state_d = STABLE_LO;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: begin
        state_d = STABLE_LO;
        cnt_d   = '0;
      end
    endcase
  end

  // Event counter: clear first, then count a rise accepted on the same edge.
  always_comb begin
    count_d = (i_clear ? '0 : count_q) + COUNT_W'(rise_d);
  end

  // State registers with a synchronous active-low reset that overrides everything.
  always_ff @(posedge i_clk) begin
    // NOTE: sequential state uses non-blocking assignments so all registers update together.
    if (!i_reset) begin
      sync1_q <= 1'b0;
      sync2_q <= 1'b0;
      state_q <= STABLE_LO;
      cnt_q   <= '0;
      level_q <= 1'b0;
      rise_q  <= 1'b0;
      fall_q  <= 1'b0;
      count_q <= '0;
    end else begin
      sync1_q <= i_d;
      sync2_q <= sync1_q;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      level_q <= level_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      count_q <= count_d;
    end
  end

  assign o_level       = level_q;
  assign o_rise        = rise_q;
  assign o_fall        = fall_q;
  assign o_busy        = (state_q == CHECK_HI) || (state_q == CHECK_LO);
  assign o_event_count = count_q;

endmodule

// File: doc/bit_debouncer.md
BIT_DEBOUNCER -- requirements
Module: bit_debouncer

Interface
REQ-001 Parameter DEBOUNCE_CYCLES, default 8: consecutive mismatching cycles required to accept a new level; legal range 1..65535.
REQ-002 Parameter COUNT_W, default 16: width of the rising-edge event counter; legal range 1..32.
REQ-003 Port i_clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 Port i_reset, input, 1: synchronous, active-low reset; sampled on the i_clk rising edge only.
REQ-005 Port i_d, input, 1: raw bit from the upstream dff stage (its o_q); may glitch or bounce.
REQ-006 Port i_clear, input, 1: synchronous clear of o_event_count.
REQ-007 Port o_level, output, 1: debounced level.
REQ-008 Port o_rise, output, 1: one-cycle pulse when o_level goes 0->1.
REQ-009 Port o_fall, output, 1: one-cycle pulse when o_level goes 1->0.
REQ-010 Port o_busy, output, 1: high while a candidate transition is being qualified.
REQ-011 Port o_event_count, output, COUNT_W: count of accepted rising edges.

Function
REQ-012 i_d SHALL pass through a 2-flop synchronizer (sync1, sync2); only sync2 feeds the qualification logic.
REQ-013 The FSM SHALL have exactly four states: STABLE_LO, CHECK_HI, STABLE_HI, CHECK_LO.
REQ-014 In STABLE_LO, sync2=1 SHALL move to CHECK_HI with the qualification counter at 1; in STABLE_HI, sync2=0 SHALL move to CHECK_LO with the counter at 1.
REQ-015 In a CHECK state, sync2 equal to o_level SHALL return the FSM to the matching STABLE state, clear the counter and leave o_level unchanged (glitch rejected).
REQ-016 In a CHECK state, a mismatch SHALL increment the counter while it is below DEBOUNCE_CYCLES.
REQ-017 The edge that observes the DEBOUNCE_CYCLES-th consecutive mismatch SHALL toggle o_level, clear the counter and enter the opposite STABLE state.
REQ-018 When DEBOUNCE_CYCLES=1, the first mismatch SHALL toggle o_level directly from the STABLE state, and the CHECK states SHALL never be entered.
REQ-019 Total latency from the first edge sampling a stable new i_d to the o_level change SHALL be DEBOUNCE_CYCLES+2 clock edges.
REQ-020 o_rise/o_fall SHALL be registered and high for exactly the one cycle following the edge that toggles o_level; they SHALL never be high together.
REQ-021 o_busy SHALL be high exactly when the FSM is in CHECK_HI or CHECK_LO.
REQ-022 Each o_rise SHALL increment o_event_count by 1 modulo 2^COUNT_W (wrap, no saturation).
REQ-023 i_clear=1 SHALL load o_event_count with 0, or with 1 if a rise is accepted on the same edge (clear then count).
REQ-024 The qualification counter SHALL be wide enough for DEBOUNCE_CYCLES and SHALL never wrap.

Reset
REQ-025 i_reset=0 at a rising edge SHALL force: sync1=sync2=0, FSM=STABLE_LO, counter=0, o_level=0, o_rise=0, o_fall=0, o_busy=0, o_event_count=0.
REQ-026 Reset SHALL override i_clear and any in-progress qualification; an interrupted CHECK SHALL be abandoned with no pulse.
REQ-027 After reset deasserts, i_d=1 SHALL be treated as a fresh transition requiring full qualification.

Verification
REQ-028 DEBOUNCE_CYCLES=4: reset, then i_d=1 held -> o_level=1 and o_rise=1 for one cycle, 6 edges after i_d first sampled high; o_event_count=1.
REQ-029 DEBOUNCE_CYCLES=4, o_level=0: i_d high for 3 cycles then low -> o_level stays 0, no o_rise, o_busy high for 3 cycles then 0.
REQ-030 DEBOUNCE_CYCLES=4, o_level=1: i_d=0 held -> o_fall one cycle, o_level=0, o_event_count unchanged.
REQ-031 COUNT_W=2: 5 qualified rises -> o_event_count sequence 1,2,3,0,1.
REQ-032 i_clear asserted on the same edge as a rise acceptance with count=2 -> o_event_count=1; i_clear alone -> 0.
REQ-033 i_reset=0 while in CHECK_HI with counter=3 -> next cycle all outputs 0, FSM STABLE_LO, no o_rise.
